// File: rtl/humidity_frame_decoder_if.sv
// Signal bundle between the humidity sensor reader side and the frame decoder.
// The reader (master) drives the transfer state, the 40-bit frame and the 5 s strobe.
// The decoder (slave) drives the decoded readings and status.
interface humidity_frame_decoder_if;
  logic [2:0]  mstate;
  logic [39:0] HYM2;
  logic        flag_five_sec;
  logic [7:0]  hum;
  logic [7:0]  temp;
  logic        upd;
  logic        valid;
  logic        stale;
  logic        fan_on;
  logic [7:0]  err_cnt;

  modport master (
    output mstate, HYM2, flag_five_sec,
    input  hum, temp, upd, valid, stale, fan_on, err_cnt
  );

  modport slave (
    input  mstate, HYM2, flag_five_sec,
    output hum, temp, upd, valid, stale, fan_on, err_cnt
  );
endinterface

// File: rtl/humidity_frame_decoder.sv
// Humidity frame decoder: latches the reader's 40-bit frame when a transfer
// completes, verifies its checksum, publishes integer humidity/temperature,
// drives a hysteretic fan request and flags stale data.
// Optional build macro HUM_AVG_EN: adds a 4-sample moving average of good
// humidity readings (one extra FSM state, upd one cycle later).
module humidity_frame_decoder #(
  parameter int HUM_ON        = 60,
  parameter int HUM_OFF       = 50,
  parameter int STALE_PERIODS = 3
) (
  input  logic                     clk1M,
  input  logic                     rst,
  humidity_frame_decoder_if.slave  bus
);

  localparam logic [7:0] HUM_ON_B    = 8'(HUM_ON);
  localparam logic [7:0] HUM_OFF_B   = 8'(HUM_OFF);
  localparam logic [3:0] STALE_MAX_B = 4'(STALE_PERIODS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CAPT  = 3'd1,
    S_CHECK = 3'd2,
    S_AVG   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  mstate_q;
  logic [39:0] frame_q;
  logic [7:0]  sum_q;
  logic        flag_q;
  logic [3:0]  stale_cnt_q;
  logic [7:0]  hum_q, temp_q, err_cnt_q;
  logic        upd_q, valid_q, stale_q, fan_on_q;

  logic        done;
  logic        flag_rise;
  logic [7:0]  sum_calc;
  logic        good_calc;
  logic        latch_frame;
  logic        commit_good;
  logic        commit_bad;
  logic [7:0]  new_hum;
  logic        fan_next;

  // A transfer completes on the first cycle the reader sits in state 3.
  assign done      = (bus.mstate == 3'd3) && (mstate_q != 3'd3);
  assign flag_rise = bus.flag_five_sec && !flag_q;

  // Checksum is the 8-bit modulo sum of the four data bytes.
  assign sum_calc  = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
  // An all-zero frame means the sensor is absent, even though its checksum matches.
  assign good_calc = (sum_q == frame_q[7:0]) && (frame_q != 40'd0);

`ifdef HUM_AVG_EN
  logic       hist_push;
  logic       have_good_q;
  logic [7:0] hist_q [4];
  logic [7:0] hist_d [4];
  logic [9:0] hist_sum;

  // History shifts one place per good frame; the first good frame fills every slot.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        assign hist_d[gi] = hist_push ? frame_q[39:32] : hist_q[gi];
      end else begin : g_tail
        assign hist_d[gi] = !hist_push  ? hist_q[gi] :
                            have_good_q ? hist_q[gi-1] : frame_q[39:32];
      end
    end
  endgenerate

  assign hist_sum = {2'b00, hist_q[0]} + {2'b00, hist_q[1]}
                  + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
  assign new_hum  = hist_sum[9:2];

  // History registers and the "a good sample exists" marker.
  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) begin
      have_good_q <= 1'b0;
      for (int i = 0; i < 4; i++) hist_q[i] <= 8'd0;
    end else begin
      if (hist_push) have_good_q <= 1'b1;
      for (int i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
    end
  end
`else
  assign new_hum = frame_q[39:32];
`endif

  // Hysteresis on the newly published humidity; the dead band holds the old request.
  always_comb begin
    fan_next = fan_on_q;
    if (new_hum >= HUM_ON_B)       fan_next = 1'b1;
    else if (new_hum <= HUM_OFF_B) fan_next = 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and per-state strobes. Results are registered on the edge
  // into OUT so that upd and the new readings are visible during OUT.
  always_comb begin
    state_d     = state_q;
    latch_frame = 1'b0;
    commit_good = 1'b0;
    commit_bad  = 1'b0;
`ifdef HUM_AVG_EN
    hist_push   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (done) begin
          latch_frame = 1'b1;
          state_d     = S_CAPT;
        end
      end
      S_CAPT: state_d = S_CHECK;
      S_CHECK: begin
`ifdef HUM_AVG_EN
        if (good_calc) begin
          hist_push = 1'b1;
          state_d   = S_AVG;
        end else begin
          commit_bad = 1'b1;
          state_d    = S_OUT;
        end
`else
        commit_good = good_calc;
        commit_bad  = !good_calc;
        state_d     = S_OUT;
`endif
      end
`ifdef HUM_AVG_EN
      S_AVG: begin
        commit_good = 1'b1;
        state_d     = S_OUT;
      end
`endif
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Input delay copies and frame capture/checksum pipeline.
  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) begin
      mstate_q <= 3'd0;
      flag_q   <= 1'b0;
      frame_q  <= 40'd0;
      sum_q    <= 8'd0;
    end else begin
      mstate_q <= bus.mstate;
      flag_q   <= bus.flag_five_sec;
      if (latch_frame)        frame_q <= bus.HYM2;
      if (state_q == S_CAPT)  sum_q   <= sum_calc;
    end
  end

  // Published readings, fan request and staleness; a good frame overrides a same-cycle 5 s edge.
  always_ff @(posedge clk1M or posedge rst) begin
    if (rst) begin
      hum_q       <= 8'd0;
      temp_q      <= 8'd0;
      upd_q       <= 1'b0;
      valid_q     <= 1'b0;
      stale_q     <= 1'b0;
      fan_on_q    <= 1'b0;
      stale_cnt_q <= 4'd0;
    end else begin
      upd_q <= commit_good;
      if (commit_good) begin
        hum_q       <= new_hum;
        temp_q      <= frame_q[23:16];
        fan_on_q    <= fan_next;
        valid_q     <= 1'b1;
        stale_q     <= 1'b0;
        stale_cnt_q <= 4'd0;
      end else if (flag_rise && (stale_cnt_q != STALE_MAX_B)) begin
        stale_cnt_q <= stale_cnt_q + 4'd1;
        if (stale_cnt_q + 4'd1 == STALE_MAX_B) begin
          stale_q  <= 1'b1;
          valid_q  <= 1'b0;
          fan_on_q <= 1'b0;
        end
      end
    end
  end

  // Rejected-frame counter, saturating.
  always_ff @(posedge clk1M or posedge rst) begin
    if (rst)                               err_cnt_q <= 8'd0;
    else if (commit_bad && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign bus.hum     = hum_q;
  assign bus.temp    = temp_q;
  assign bus.upd     = upd_q;
  assign bus.valid   = valid_q;
  assign bus.stale   = stale_q;
  assign bus.fan_on  = fan_on_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_humidity_frame_decoder.sv
// Directed bench for humidity_frame_decoder with hand-computed expectations.
module tb_humidity_frame_decoder;

`ifdef HUM_AVG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic clk1M = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   upd_at;

  humidity_frame_decoder_if bus();

  humidity_frame_decoder dut (
    .clk1M (clk1M),
    .rst   (rst),
    .bus   (bus)
  );

  always #500 clk1M = ~clk1M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Present a frame, enter mstate 3 (cycle E), report the first cycle after E with upd high (0 = none).
  task automatic send_frame(input logic [39:0] f, output int first_upd);
    first_upd = 0;
    @(negedge clk1M);
    bus.HYM2   = f;
    bus.mstate = 3'd2;
    @(negedge clk1M);
    bus.mstate = 3'd3;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk1M);
      if (bus.upd && first_upd == 0) first_upd = k;
    end
    bus.mstate = 3'd2;
    $display("frame %h: upd at E+%0d hum=%0d temp=%0d fan=%0d err=%0d",
             f, first_upd, bus.hum, bus.temp, bus.fan_on, bus.err_cnt);
  endtask

  task automatic pulse_flag();
    @(negedge clk1M);
    bus.flag_five_sec = 1'b1;
    @(negedge clk1M);
    bus.flag_five_sec = 1'b0;
    @(negedge clk1M);
    $display("5s edge: stale=%0d valid=%0d fan=%0d", bus.stale, bus.valid, bus.fan_on);
  endtask

  initial begin
    rst               = 1'b1;
    bus.mstate        = 3'd0;
    bus.HYM2          = 40'd0;
    bus.flag_five_sec = 1'b0;
    repeat (3) @(negedge clk1M);
    check("rst_hum",   32'(bus.hum),     0);
    check("rst_temp",  32'(bus.temp),    0);
    check("rst_upd",   32'(bus.upd),     0);
    check("rst_valid", 32'(bus.valid),   0);
    check("rst_stale", 32'(bus.stale),   0);
    check("rst_fan",   32'(bus.fan_on),  0);
    check("rst_err",   32'(bus.err_cnt), 0);
    rst = 1'b0;
    @(negedge clk1M);

`ifdef HUM_AVG_EN
    send_frame(40'h280017003F, upd_at);
    check("avg1_lat", 32'(upd_at),  LAT);
    check("avg1_hum", 32'(bus.hum), 40);
    send_frame(40'h5000170067, upd_at);
    check("avg2_lat", 32'(upd_at),  LAT);
    check("avg2_hum", 32'(bus.hum), 50);
    check("avg2_temp", 32'(bus.temp), 23);
`else
    // Basic decode
    send_frame(40'h2D00170044, upd_at);
    check("t1_lat",   32'(upd_at),      LAT);
    check("t1_hum",   32'(bus.hum),     45);
    check("t1_temp",  32'(bus.temp),    23);
    check("t1_valid", 32'(bus.valid),   1);
    check("t1_fan",   32'(bus.fan_on),  0);
    check("t1_err",   32'(bus.err_cnt), 0);

    // Bad checksum, then all-zero frame
    send_frame(40'h2D00170045, upd_at);
    check("t2a_noupd", 32'(upd_at), 0);
    send_frame(40'h0000000000, upd_at);
    check("t2b_noupd", 32'(upd_at),      0);
    check("t2_err",    32'(bus.err_cnt), 2);
    check("t2_hum",    32'(bus.hum),     45);
    check("t2_temp",   32'(bus.temp),    23);

    // Hysteresis
    send_frame(40'h460017005D, upd_at);
    check("t3_hum70", 32'(bus.hum),    70);
    check("t3_fan70", 32'(bus.fan_on), 1);
    send_frame(40'h370017004E, upd_at);
    check("t3_fan55", 32'(bus.fan_on), 1);
    send_frame(40'h3200170049, upd_at);
    check("t3_fan50", 32'(bus.fan_on), 0);

    // Staleness
    send_frame(40'h460017005D, upd_at);
    check("t4_fan_pre", 32'(bus.fan_on), 1);
    pulse_flag();
    pulse_flag();
    check("t4_stale2", 32'(bus.stale), 0);
    check("t4_valid2", 32'(bus.valid), 1);
    pulse_flag();
    check("t4_stale3", 32'(bus.stale),  1);
    check("t4_valid3", 32'(bus.valid),  0);
    check("t4_fan3",   32'(bus.fan_on), 0);
    check("t4_hum3",   32'(bus.hum),    70);
    send_frame(40'h2D00170044, upd_at);
    check("t4_stale_clr", 32'(bus.stale), 0);
    check("t4_valid_set", 32'(bus.valid), 1);
    check("t4_hum",       32'(bus.hum),   45);

    // Reset while the FSM is in CHECK
    @(negedge clk1M);
    bus.HYM2   = 40'h460017005D;
    bus.mstate = 3'd2;
    @(negedge clk1M);
    bus.mstate = 3'd3;          // E
    @(negedge clk1M);           // CAPT
    @(negedge clk1M);           // CHECK
    rst        = 1'b1;
    bus.mstate = 3'd2;
    @(negedge clk1M);
    rst = 1'b0;
    check("t5_hum",   32'(bus.hum),     0);
    check("t5_temp",  32'(bus.temp),    0);
    check("t5_valid", 32'(bus.valid),   0);
    check("t5_fan",   32'(bus.fan_on),  0);
    check("t5_err",   32'(bus.err_cnt), 0);
    check("t5_upd",   32'(bus.upd),     0);
    repeat (4) @(negedge clk1M);
    check("t5_idle_upd", 32'(bus.upd), 0);
    send_frame(40'h2D00170044, upd_at);
    check("t5_lat",   32'(upd_at),    LAT);
    check("t5_hum2",  32'(bus.hum),   45);
    check("t5_valid2", 32'(bus.valid), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
